// File: rtl/l1_line_cache.sv
// Direct-mapped write-back, write-allocate L1 cache for 128-bit lines.
// Wishbone-style slave toward the datapath, Wishbone-style master toward memory.
module l1_line_cache #(
  parameter int SETS_LOG2 = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cpu_cyc,
  input  logic         cpu_stb,
  input  logic         cpu_we,
  input  logic [11:0]  cpu_adr,
  input  logic [15:0]  cpu_sel,
  input  logic [127:0] cpu_dat_m,
  output logic [127:0] cpu_dat_s,
  output logic         cpu_ack,
  output logic         mem_cyc,
  output logic         mem_stb,
  output logic         mem_we,
  output logic [11:0]  mem_adr,
  output logic [15:0]  mem_sel,
  output logic [127:0] mem_dat_m,
  input  logic [127:0] mem_dat_s,
  input  logic         mem_ack
);

  localparam int SETS  = 1 << SETS_LOG2;
  localparam int TAG_W = 12 - SETS_LOG2;

  typedef enum logic [1:0] {
    IDLE,
    WRITEBACK,
    FILL
  } state_t;

  state_t state;

  logic [127:0]         data_q [SETS];
  logic [TAG_W-1:0]     tag_q  [SETS];
  logic [SETS-1:0]      valid_q;
  logic [SETS-1:0]      dirty_q;
  logic [11:0]          miss_adr;

  logic                 req;
  logic                 hit;
  logic [SETS_LOG2-1:0] idx;
  logic [TAG_W-1:0]     tag;
  logic [SETS_LOG2-1:0] m_idx;
  logic [TAG_W-1:0]     m_tag;
  logic [127:0]         wr_line;
  logic                 fill_done;
  logic                 wr_hit;

  assign req   = cpu_cyc & cpu_stb;
  assign idx   = cpu_adr[SETS_LOG2-1:0];
  assign tag   = cpu_adr[11:SETS_LOG2];
  assign m_idx = miss_adr[SETS_LOG2-1:0];
  assign m_tag = miss_adr[11:SETS_LOG2];

  assign hit = req & valid_q[idx] & (tag_q[idx] == tag);

  // Hits complete combinationally so the pipeline never stalls on them
  assign cpu_ack   = (state == IDLE) & hit;
  assign cpu_dat_s = cpu_ack ? data_q[idx] : '0;

  assign wr_hit    = cpu_ack & cpu_we;
  assign fill_done = (state == FILL) & mem_ack;

  always_comb begin
    wr_line = data_q[idx];
    for (int i = 0; i < 16; i++) begin
      if (cpu_sel[i]) begin
        wr_line[8*i +: 8] = cpu_dat_m[8*i +: 8];
      end
    end
  end

  // Line data and tags carry no reset; valid bits guard them
  always_ff @(posedge clk) begin
    if (fill_done) begin
      data_q[m_idx] <= mem_dat_s;
      tag_q[m_idx]  <= m_tag;
    end else if (wr_hit) begin
      data_q[idx] <= wr_line;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      valid_q   <= '0;
      dirty_q   <= '0;
      miss_adr  <= '0;
      mem_cyc   <= 1'b0;
      mem_stb   <= 1'b0;
      mem_we    <= 1'b0;
      mem_adr   <= '0;
      mem_sel   <= '0;
      mem_dat_m <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req && !hit) begin
            miss_adr <= cpu_adr;
            mem_cyc  <= 1'b1;
            mem_stb  <= 1'b1;
            mem_sel  <= '1;
            if (valid_q[idx] && dirty_q[idx]) begin
              mem_we    <= 1'b1;
              mem_adr   <= {tag_q[idx], idx};
              mem_dat_m <= data_q[idx];
              state     <= WRITEBACK;
            end else begin
              mem_we    <= 1'b0;
              mem_adr   <= cpu_adr;
              mem_dat_m <= '0;
              state     <= FILL;
            end
          end else if (wr_hit) begin
            dirty_q[idx] <= 1'b1;
          end
        end
        WRITEBACK: begin
          if (mem_ack) begin
            dirty_q[m_idx] <= 1'b0;
            mem_we         <= 1'b0;
            mem_adr        <= miss_adr;
            mem_dat_m      <= '0;
            state          <= FILL;
          end
        end
        FILL: begin
          if (mem_ack) begin
            valid_q[m_idx] <= 1'b1;
            dirty_q[m_idx] <= 1'b0;
            mem_cyc        <= 1'b0;
            mem_stb        <= 1'b0;
            mem_we         <= 1'b0;
            mem_adr        <= '0;
            mem_sel        <= '0;
            mem_dat_m      <= '0;
            state          <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_l1_line_cache.sv
// Directed bench for l1_line_cache: fills, write merge, writeback,
// slow memory, reset mid-fill, strobe drop and write-allocate.
module tb_l1_line_cache;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         cpu_cyc = 1'b0;
  logic         cpu_stb = 1'b0;
  logic         cpu_we = 1'b0;
  logic [11:0]  cpu_adr = '0;
  logic [15:0]  cpu_sel = '0;
  logic [127:0] cpu_dat_m = '0;
  logic [127:0] cpu_dat_s;
  logic         cpu_ack;
  logic         mem_cyc;
  logic         mem_stb;
  logic         mem_we;
  logic [11:0]  mem_adr;
  logic [15:0]  mem_sel;
  logic [127:0] mem_dat_m;
  logic [127:0] mem_dat_s = '0;
  logic         mem_ack = 1'b0;

  int vecs = 0;
  int errs = 0;

  localparam logic [127:0] L  = 128'h0f0e0d0c_0b0a0908_07060504_03020100;
  localparam logic [127:0] LM = 128'h0f0e0d0c_0b0a0908_07060504_0302beef;
  localparam logic [127:0] L2 = 128'h22222222_33333333_44444444_55555555;
  localparam logic [127:0] L3 = 128'hdeadbeef_cafef00d_01234567_89abcdef;
  localparam logic [127:0] L4 = 128'h44444444_44444444_44444444_44444444;
  localparam logic [127:0] L5 = 128'h55555555_55555555_55555555_55555555;
  localparam logic [127:0] W5 = 128'haa112233_44556677_8899aabb_ccddeeff;
  localparam logic [127:0] E5 = 128'haa555555_55555555_55555555_55555555;

  l1_line_cache #(.SETS_LOG2(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_cyc(cpu_cyc), .cpu_stb(cpu_stb), .cpu_we(cpu_we),
    .cpu_adr(cpu_adr), .cpu_sel(cpu_sel), .cpu_dat_m(cpu_dat_m),
    .cpu_dat_s(cpu_dat_s), .cpu_ack(cpu_ack),
    .mem_cyc(mem_cyc), .mem_stb(mem_stb), .mem_we(mem_we),
    .mem_adr(mem_adr), .mem_sel(mem_sel), .mem_dat_m(mem_dat_m),
    .mem_dat_s(mem_dat_s), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  task automatic req(input logic we, input logic [11:0] adr,
                     input logic [15:0] sel, input logic [127:0] d);
    cpu_cyc = 1'b1; cpu_stb = 1'b1; cpu_we = we;
    cpu_adr = adr; cpu_sel = sel; cpu_dat_m = d;
  endtask

  task automatic idle_bus();
    cpu_cyc = 1'b0; cpu_stb = 1'b0; cpu_we = 1'b0;
    cpu_sel = '0; cpu_dat_m = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    @(negedge clk); @(negedge clk);
    vecs++;
    if ({cpu_ack, mem_cyc, mem_stb, mem_we} !== 4'b0) begin
      errs++; $display("FAIL reset_ctl got %b want 0000", {cpu_ack, mem_cyc, mem_stb, mem_we});
    end
    vecs++;
    if ({cpu_dat_s, mem_dat_m, mem_adr, mem_sel} !== '0) begin
      errs++; $display("FAIL reset_bus got %h/%h/%h/%h want 0", cpu_dat_s, mem_dat_m, mem_adr, mem_sel);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_read_miss();
    @(negedge clk);
    req(1'b0, 12'h010, 16'h0, '0);
    #1;
    vecs++;
    if (cpu_ack !== 1'b0) begin
      errs++; $display("FAIL rm_noack got %b want 0", cpu_ack);
    end
    @(negedge clk);
    vecs++;
    if ({mem_cyc, mem_stb, mem_we, mem_adr, mem_sel} !== {3'b110, 12'h010, 16'hffff}) begin
      errs++; $display("FAIL rm_fill got %b%b%b %h %h want 110 010 ffff",
                       mem_cyc, mem_stb, mem_we, mem_adr, mem_sel);
    end
    mem_ack = 1'b1; mem_dat_s = L;
    @(negedge clk);
    mem_ack = 1'b0; mem_dat_s = '0;
    vecs++;
    if ({cpu_ack, mem_stb} !== 2'b10 || cpu_dat_s !== L) begin
      errs++; $display("FAIL rm_ack got ack=%b stb=%b d=%h want ack=1 stb=0 d=%h",
                       cpu_ack, mem_stb, cpu_dat_s, L);
    end
    @(negedge clk);
    vecs++;
    if ({cpu_ack, mem_stb} !== 2'b10 || cpu_dat_s !== L) begin
      errs++; $display("FAIL rm_rehit got ack=%b stb=%b d=%h want ack=1 stb=0 d=%h",
                       cpu_ack, mem_stb, cpu_dat_s, L);
    end
    idle_bus();
  endtask

  task automatic test_write_hit();
    @(negedge clk);
    req(1'b1, 12'h010, 16'h0003, {112'hffff_ffff_ffff_ffff_ffff_ffff_ffff, 16'hbeef});
    #1;
    vecs++;
    if (cpu_ack !== 1'b1) begin
      errs++; $display("FAIL wh_ack got %b want 1", cpu_ack);
    end
    @(negedge clk);
    req(1'b0, 12'h010, 16'h0, '0);
    #1;
    vecs++;
    if (cpu_ack !== 1'b1 || cpu_dat_s !== LM) begin
      errs++; $display("FAIL wh_merge got ack=%b d=%h want ack=1 d=%h", cpu_ack, cpu_dat_s, LM);
    end
    idle_bus();
  endtask

  task automatic test_writeback();
    @(negedge clk);
    req(1'b0, 12'h018, 16'h0, '0);
    #1;
    vecs++;
    if (cpu_ack !== 1'b0) begin
      errs++; $display("FAIL wb_miss got %b want 0", cpu_ack);
    end
    @(negedge clk);
    vecs++;
    if ({mem_cyc, mem_stb, mem_we, mem_adr, mem_sel} !== {3'b111, 12'h010, 16'hffff}
        || mem_dat_m !== LM) begin
      errs++; $display("FAIL wb_drive got %b%b%b %h %h d=%h want 111 010 ffff d=%h",
                       mem_cyc, mem_stb, mem_we, mem_adr, mem_sel, mem_dat_m, LM);
    end
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    vecs++;
    if ({cpu_ack, mem_stb, mem_we, mem_adr} !== {3'b010, 12'h018}) begin
      errs++; $display("FAIL wb_fill got ack=%b stb=%b we=%b adr=%h want 0 1 0 018",
                       cpu_ack, mem_stb, mem_we, mem_adr);
    end
    mem_ack = 1'b1; mem_dat_s = L2;
    @(negedge clk);
    mem_ack = 1'b0; mem_dat_s = '0;
    vecs++;
    if (cpu_ack !== 1'b1 || cpu_dat_s !== L2) begin
      errs++; $display("FAIL wb_done got ack=%b d=%h want ack=1 d=%h", cpu_ack, cpu_dat_s, L2);
    end
    idle_bus();
  endtask

  task automatic test_slow_ack();
    @(negedge clk);
    req(1'b0, 12'h021, 16'h0, '0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      vecs++;
      if ({cpu_ack, mem_stb, mem_we, mem_adr} !== {3'b010, 12'h021}) begin
        errs++; $display("FAIL slow_hold%0d got ack=%b stb=%b we=%b adr=%h want 0 1 0 021",
                         i, cpu_ack, mem_stb, mem_we, mem_adr);
      end
    end
    mem_ack = 1'b1; mem_dat_s = L3;
    @(negedge clk);
    mem_ack = 1'b0; mem_dat_s = '0;
    vecs++;
    if (cpu_ack !== 1'b1 || cpu_dat_s !== L3) begin
      errs++; $display("FAIL slow_done got ack=%b d=%h want ack=1 d=%h", cpu_ack, cpu_dat_s, L3);
    end
    idle_bus();
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    req(1'b0, 12'h030, 16'h0, '0);
    @(negedge clk);
    vecs++;
    if (mem_stb !== 1'b1) begin
      errs++; $display("FAIL rmid_fill got stb=%b want 1", mem_stb);
    end
    idle_bus();
    rst_n = 1'b0;
    #1;
    vecs++;
    if ({mem_cyc, mem_stb} !== 2'b00) begin
      errs++; $display("FAIL rmid_drop got cyc=%b stb=%b want 0 0", mem_cyc, mem_stb);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    req(1'b0, 12'h010, 16'h0, '0);
    #1;
    vecs++;
    if (cpu_ack !== 1'b0) begin
      errs++; $display("FAIL rmid_miss got ack=%b want 0", cpu_ack);
    end
    @(negedge clk);
    vecs++;
    if ({mem_stb, mem_we, mem_adr} !== {2'b10, 12'h010}) begin
      errs++; $display("FAIL rmid_refill got stb=%b we=%b adr=%h want 1 0 010",
                       mem_stb, mem_we, mem_adr);
    end
    mem_ack = 1'b1; mem_dat_s = L;
    @(negedge clk);
    mem_ack = 1'b0; mem_dat_s = '0;
    vecs++;
    if (cpu_ack !== 1'b1 || cpu_dat_s !== L) begin
      errs++; $display("FAIL rmid_hit got ack=%b d=%h want ack=1 d=%h", cpu_ack, cpu_dat_s, L);
    end
    idle_bus();
  endtask

  task automatic test_stb_drop();
    @(negedge clk);
    req(1'b0, 12'h042, 16'h0, '0);
    @(negedge clk);
    cpu_stb = 1'b0;
    #1;
    vecs++;
    if ({cpu_ack, mem_stb, mem_adr} !== {2'b01, 12'h042}) begin
      errs++; $display("FAIL drop_fill got ack=%b stb=%b adr=%h want 0 1 042",
                       cpu_ack, mem_stb, mem_adr);
    end
    @(negedge clk);
    mem_ack = 1'b1; mem_dat_s = L4;
    @(negedge clk);
    mem_ack = 1'b0; mem_dat_s = '0;
    vecs++;
    if ({cpu_ack, mem_stb} !== 2'b00 || cpu_dat_s !== '0) begin
      errs++; $display("FAIL drop_noack got ack=%b stb=%b d=%h want 0 0 0",
                       cpu_ack, mem_stb, cpu_dat_s);
    end
    idle_bus();
    @(negedge clk);
    req(1'b0, 12'h042, 16'h0, '0);
    #1;
    vecs++;
    if (cpu_ack !== 1'b1 || cpu_dat_s !== L4) begin
      errs++; $display("FAIL drop_hit got ack=%b d=%h want ack=1 d=%h", cpu_ack, cpu_dat_s, L4);
    end
    idle_bus();
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    req(1'b1, 12'h055, 16'h8000, W5);
    #1;
    vecs++;
    if (cpu_ack !== 1'b0) begin
      errs++; $display("FAIL alloc_miss got ack=%b want 0", cpu_ack);
    end
    @(negedge clk);
    vecs++;
    if ({mem_stb, mem_we, mem_adr} !== {2'b10, 12'h055}) begin
      errs++; $display("FAIL alloc_fill got stb=%b we=%b adr=%h want 1 0 055",
                       mem_stb, mem_we, mem_adr);
    end
    mem_ack = 1'b1; mem_dat_s = L5;
    @(negedge clk);
    mem_ack = 1'b0; mem_dat_s = '0;
    vecs++;
    if (cpu_ack !== 1'b1) begin
      errs++; $display("FAIL alloc_wack got ack=%b want 1", cpu_ack);
    end
    @(negedge clk);
    req(1'b0, 12'h055, 16'h0, '0);
    #1;
    vecs++;
    if (cpu_ack !== 1'b1 || cpu_dat_s !== E5) begin
      errs++; $display("FAIL alloc_merge got ack=%b d=%h want ack=1 d=%h", cpu_ack, cpu_dat_s, E5);
    end
    idle_bus();
  endtask

  initial begin
    test_reset();
    test_read_miss();
    test_write_hit();
    test_writeback();
    test_slow_ack();
    test_reset_mid();
    test_stb_drop();
    test_back_to_back();
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
